bcd_scan_ctrl: RTL and testbench
================================

# bcd_scan_ctrl

Sequencing controller for the 4-digit seven-segment display behind the adder datapath. It captures a binary result (magnitude plus sign) on a load strobe and converts it to three BCD digits with an iterative shift-add-3 sequence. It then time-multiplexes the digits and a sign digit onto the shared `SSeg`/`an` pins with a programmable refresh prescaler. It sits between the arithmetic result and the board display pins, replacing a free-running combinational decode.

## Interface
- `WIDTH`, default 9: magnitude width; legal range 4..9 (max 511, fits 3 BCD digits).
- `SCAN_DIV`, default 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); minimum 2.
- `CLK_50`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `Value`  in  WIDTH  unsigned magnitude to display.
- `Neg`  in  1  sign; 1 shows minus on digit 3.
- `Load`  in  1  single-cycle start strobe; `Value`/`Neg` sampled with it.
- `Busy`  out  1  conversion in progress.
- `SSeg`  out  [0:6]  segments a..g, `SSeg[0]`=a, active-low.
- `an`  out  4  digit anodes, active-low one-hot, `an[0]` = least-significant digit.

## Operation
- Conversion FSM, 3 states:
  - IDLE: accept `Load`.
  - CONV: `WIDTH` iterations. Each one first adds 3 to every BCD nibble ≥5, then shifts left 1 with the next MSB of the captured value.
  - DONE: copies the BCD result and sign atomically into the display registers, then returns to IDLE.
- `Load` in IDLE captures `Value` and `Neg` and enters CONV. `Load` in CONV or DONE is ignored, not queued.
- The display keeps showing the previous result throughout a conversion. No partial digits are ever shown.
- Scan:
  - The prescaler counts 0..`SCAN_DIV`-1. At the terminal count the digit index advances 0→1→2→3→0.
  - `an` = ~(1 << index).
- Digit content:
  - Digits 0..2 show BCD ones/tens/hundreds.
  - Digit 3 shows minus (1111110) when the stored sign is 1, otherwise blank (1111111).
- Glyphs: 0=0000001, 2=0010010, 5=0100100, 6=0100000.

## Timing
- Reset values: state IDLE, `Busy`=0, `an`=1111, `SSeg`=1111111, display registers 0, sign 0, prescaler 0, index 0.
- `SSeg` and `an` are registered. The first cycle after `RST` falls they drive `an`=1110 with the glyph for 0.
- `Busy` rises on the edge that samples `Load` and stays high exactly `WIDTH`+1 cycles (CONV plus DONE).
- New digits reach `SSeg` one cycle after `Busy` falls, in whichever slot is active. Scan phase is not disturbed.
- `RST` at any time, including mid-CONV, returns everything to reset values on the next edge. An in-flight conversion is discarded.
- `Load` on the same edge `RST` is high is ignored.
- `Value` ≥ 2^`WIDTH` cannot occur. Overflow handling is not required.

## Configuration
- `BCD_LZB_EN` defined: leading-zero blanking.
  - Hundreds digit blank if 0.
  - Tens digit blank if hundreds and tens are both 0.
  - Ones digit always shown.
  - The minus sign stays on digit 3 regardless.
- Undefined: all three digits always shown, including leading zeros.

## Structure
- Shared package `bcd_pkg`:
  - FSM state encodings (IDLE/CONV/DONE).
  - `SEG_BLANK` and `SEG_MINUS` constants.
  - Digit count (4).
- One sub-module, `bcd7seg`: combinational 4-bit BCD to active-low [0:6] glyph, instanced once on the muxed digit.
- The FSM, double-dabble registers, prescaler and anode mux live in the top.

## Test plan
Bench uses `SCAN_DIV`=4, `WIDTH`=9.
- Reset: `RST`=1 for 3 cycles → `an`=1111, `SSeg`=1111111, `Busy`=0. One cycle after release → `an`=1110, `SSeg`=0000001.
- `Load` with `Value`=256, `Neg`=0 → `Busy` high 10 cycles. Then across slots: digit 0 = 0100000, digit 1 = 0100100, digit 2 = 0010010, digit 3 = 1111111.
- With `BCD_LZB_EN`: `Value`=5, `Neg`=1 → digit 3 = 1111110, digits 2 and 1 = 1111111, digit 0 = 0100100. Without the macro, digits 2 and 1 = 0000001.
- `Load` pulses with `Value`=7 at cycles 2 and 5 of an active conversion of 256 → ignored, display shows 256, `Busy` width unchanged.
- Scan wrap: `an` steps 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles, and is undisturbed by a concurrent conversion.
- `RST` at cycle 4 of CONV → next edge `Busy`=0 and `an`=1111; after release the display shows 0, not the aborted value.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD display scan controller:
// FSM encoding, special glyphs, digit count and the double-dabble adjust step.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } bcd_state_e;

   localparam int        NUM_DIGITS = 4;
   localparam logic [0:6] SEG_BLANK = 7'b1111111;
   localparam logic [0:6] SEG_MINUS = 7'b1111110;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
   function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
      logic [11:0] r;
      for (int i = 0; i < 3; i++) begin
         r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_scan_bcd7seg.sv
// Combinational BCD digit to active-low seven-segment glyph, bit 0 = segment a.
// Non-decimal codes render blank.
module bcd7seg
   import bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [0:6] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = 7'b0000001;
         4'd1: seg = 7'b1001111;
         4'd2: seg = 7'b0010010;
         4'd3: seg = 7'b0000110;
         4'd4: seg = 7'b1001100;
         4'd5: seg = 7'b0100100;
         4'd6: seg = 7'b0100000;
         4'd7: seg = 7'b0001111;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0000100;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Captures a signed-magnitude result, converts it to BCD by shift-add-3 and
// scans it onto a 4-digit display. Define BCD_LZB_EN for leading-zero blanking.
module bcd_scan_ctrl
   import bcd_pkg::*;
#(
   parameter int WIDTH    = 9,
   parameter int SCAN_DIV = 50000
) (
   input  logic             CLK_50,
   input  logic             RST,
   input  logic [WIDTH-1:0] Value,
   input  logic             Neg,
   input  logic             Load,
   output logic             Busy,
   output logic [0:6]       SSeg,
   output logic [3:0]       an
);

   localparam int PW    = $clog2(SCAN_DIV);
   localparam int CW    = $clog2(WIDTH);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH - 1);

`ifdef BCD_LZB_EN
   localparam logic LZB = 1'b1;
`else
   localparam logic LZB = 1'b0;
`endif

   bcd_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [11:0]      bcd_q, bcd_d;
   logic             neg_cap_q, neg_cap_d;
   logic [11:0]      disp_q, disp_d;
   logic             sign_q, sign_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [0:6]       sseg_q, sseg_d;

   logic [11:0] bcd_adj;
   logic        unused_adj_msb;
   logic [3:0]  nib;
   logic [0:6]  glyph;
   logic        blank_hund, blank_tens;

   assign bcd_adj = dabble_adjust(bcd_q);
   // Hundreds never exceeds 2 before the final shift, so its top bit is always shifted out.
   assign unused_adj_msb = bcd_adj[11];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      bcd_d     = bcd_q;
      neg_cap_d = neg_cap_q;
      disp_d    = disp_q;
      sign_d    = sign_q;
      case (state_q)
         ST_IDLE: begin
            if (Load) begin
               state_d   = ST_CONV;
               shift_d   = Value;
               neg_cap_d = Neg;
               bcd_d     = '0;
               cnt_d     = '0;
            end
         end
         ST_CONV: begin
            bcd_d   = {bcd_adj[10:0], shift_q[WIDTH-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) state_d = ST_DONE;
         end
         ST_DONE: begin
            disp_d  = bcd_q;
            sign_d  = neg_cap_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   bcd7seg u_bcd7seg (
      .digit (nib),
      .seg   (glyph)
   );

   always_comb begin
      presc_d    = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      idx_d      = (presc_q == PRESC_MAX) ? idx_q + 1'b1 : idx_q;
      an_d       = ~(4'b0001 << idx_q);
      blank_hund = LZB && (disp_q[11:8] == 4'd0);
      blank_tens = blank_hund && (disp_q[7:4] == 4'd0);
      nib        = disp_q[3:0];
      sseg_d     = glyph;
      case (idx_q)
         2'd1: begin
            nib = disp_q[7:4];
            if (blank_tens) sseg_d = SEG_BLANK;
         end
         2'd2: begin
            nib = disp_q[11:8];
            if (blank_hund) sseg_d = SEG_BLANK;
         end
         2'd3: sseg_d = sign_q ? SEG_MINUS : SEG_BLANK;
         default: nib = disp_q[3:0];
      endcase
   end

   always_ff @(posedge CLK_50) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         disp_q  <= '0;
         sign_q  <= 1'b0;
         presc_q <= '0;
         idx_q   <= '0;
         an_q    <= 4'b1111;
         sseg_q  <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         sign_q  <= sign_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
      end
   end

   // Conversion scratch is fully reloaded on every accepted Load.
   always_ff @(posedge CLK_50) begin
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      neg_cap_q <= neg_cap_d;
   end

   assign Busy = (state_q != ST_IDLE);
   assign SSeg = sseg_q;
   assign an   = an_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl (WIDTH=9, SCAN_DIV=4): decimal-arithmetic reference model
// checked every cycle, plus directed literal expectations.
module tb_bcd_scan_ctrl;

   logic       clk;
   logic       RST;
   logic [8:0] Value;
   logic       Neg;
   logic       Load;
   logic       Busy;
   logic [0:6] SSeg;
   logic [3:0] an;

   int checks   = 0;
   int failures = 0;

   bcd_scan_ctrl #(.WIDTH(9), .SCAN_DIV(4)) dut (
      .CLK_50 (clk),
      .RST    (RST),
      .Value  (Value),
      .Neg    (Neg),
      .Load   (Load),
      .Busy   (Busy),
      .SSeg   (SSeg),
      .an     (an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BCD_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   localparam logic [0:6] G_BLANK = 7'b1111111;
   localparam logic [0:6] G_MINUS = 7'b1111110;
   logic [0:6] gl [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

   // Reference model: displayed number as an integer, digits by decimal division.
   bit         m_valid = 1'b0;
   int         k, bcnt, mdisp, cap;
   bit         msign, capn;
   logic       m_busy;
   logic [3:0] m_an;
   logic [0:6] m_seg;

   function automatic logic [0:6] exp_seg(int slot, int v, bit s);
      logic [0:6] r;
      case (slot)
         3: r = s ? G_MINUS : G_BLANK;
         2: r = (LZB && v < 100) ? G_BLANK : gl[v / 100];
         1: r = (LZB && v < 10) ? G_BLANK : gl[(v / 10) % 10];
         default: r = gl[v % 10];
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (RST) begin
         m_valid = 1'b1;
         k = 0; bcnt = 0; mdisp = 0; msign = 1'b0;
         m_an = 4'b1111; m_seg = G_BLANK; m_busy = 1'b0;
      end else if (m_valid) begin
         m_an  = 4'b1111;
         m_an[(k / 4) % 4] = 1'b0;
         m_seg = exp_seg((k / 4) % 4, mdisp, msign);
         k++;
         if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0) begin
               mdisp = cap;
               msign = capn;
            end
         end else if (Load) begin
            bcnt = 10;
            cap  = int'(Value);
            capn = Neg;
         end
         m_busy = (bcnt > 0);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_busy", 32'(Busy), 32'(m_busy));
         chk("model_an", 32'(an), 32'(m_an));
         chk("model_sseg", 32'(SSeg), 32'(m_seg));
      end
   end

   task automatic load(input int v, input bit n);
      @(negedge clk);
      Value = 9'(v); Neg = n; Load = 1'b1;
      @(negedge clk);
      Load = 1'b0;
   endtask

   task automatic busy_width(output int w, input bit pulse);
      w = 0;
      while (Busy && w < 50) begin
         w++;
         if (pulse && (w == 2 || w == 5)) begin
            Value = 9'd7; Load = 1'b1;
         end else begin
            Load = 1'b0;
         end
         @(negedge clk);
      end
      Load = 1'b0;
   endtask

   task automatic check_slot(input string name, input int d, input logic [0:6] exp);
      logic [3:0] tgt;
      int n;
      tgt = 4'b1111;
      tgt[d] = 1'b0;
      n = 0;
      while (an !== tgt && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk({name, "_timeout"}, 32'(an), 32'(tgt));
      else chk(name, 32'(SSeg), 32'(exp));
   endtask

   logic [3:0] seq [0:4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

   initial begin
      int w;
      int n;
      logic [3:0] prev;
      RST = 1'b1; Load = 1'b0; Value = '0; Neg = 1'b0;

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(an), 32'h0000000F);
      chk("rst_sseg", 32'(SSeg), 32'h7F);
      chk("rst_busy", 32'(Busy), 32'h0);
      RST = 1'b0;
      @(negedge clk);
      chk("post_rst_an", 32'(an), 32'hE);
      chk("post_rst_sseg", 32'(SSeg), 32'(7'b0000001));

      // 256, positive
      load(256, 1'b0);
      busy_width(w, 1'b0);
      chk("busy_width_256", 32'(w), 32'd10);
      @(negedge clk);
      check_slot("d0_256", 0, 7'b0100000);
      check_slot("d1_256", 1, 7'b0100100);
      check_slot("d2_256", 2, 7'b0010010);
      check_slot("d3_256", 3, 7'b1111111);

      // 5, negative
      load(5, 1'b1);
      busy_width(w, 1'b0);
      chk("busy_width_5", 32'(w), 32'd10);
      @(negedge clk);
      check_slot("d3_neg5", 3, 7'b1111110);
      check_slot("d2_neg5", 2, LZB ? 7'b1111111 : 7'b0000001);
      check_slot("d1_neg5", 1, LZB ? 7'b1111111 : 7'b0000001);
      check_slot("d0_neg5", 0, 7'b0100100);

      // Load pulses during an active conversion are dropped
      load(256, 1'b0);
      busy_width(w, 1'b1);
      chk("busy_width_ignored", 32'(w + 1), 32'd11);
      @(negedge clk);
      check_slot("d0_ign", 0, 7'b0100000);
      check_slot("d1_ign", 1, 7'b0100100);
      check_slot("d2_ign", 2, 7'b0010010);
      check_slot("d3_ign", 3, 7'b1111111);

      // Scan wrap with a concurrent conversion of 33
      n = 0;
      prev = an;
      @(negedge clk);
      while (!(an === 4'b1110 && prev !== 4'b1110) && n < 40) begin
         prev = an;
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("scan_sync_timeout", 32'(an), 32'hE);
      for (int i = 0; i < 17; i++) begin
         chk("scan_wrap_an", 32'(an), 32'(seq[i / 4]));
         if (i == 0) begin
            Value = 9'd33; Neg = 1'b0; Load = 1'b1;
         end else begin
            Load = 1'b0;
         end
         @(negedge clk);
      end
      Load = 1'b0;
      check_slot("d1_33", 1, 7'b0000110);

      // Reset in the middle of a conversion of -123
      load(123, 1'b1);
      repeat (3) @(negedge clk);
      RST = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(Busy), 32'h0);
      chk("abort_an", 32'(an), 32'hF);
      RST = 1'b0;
      @(negedge clk);
      chk("abort_post_an", 32'(an), 32'hE);
      chk("abort_post_d0", 32'(SSeg), 32'(7'b0000001));
      check_slot("abort_d3", 3, 7'b1111111);
      check_slot("abort_d2", 2, LZB ? 7'b1111111 : 7'b0000001);
      repeat (12) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
